// File: rtl/iq_sample_sched.sv
// Round-robin scheduler that accepts 4-bit signed samples from NCH lanes and
// delivers them offset-converted to 7-bit unsigned through a single output register.
module iq_sample_sched #(
    parameter int NCH   = 2,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NCH-1:0]          ch_mask,
    input  logic [NCH-1:0]          req_valid,
    input  logic [4*NCH-1:0]        req_data,
    output logic [NCH-1:0]          req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [6:0]              out_data,
    output logic [$clog2(NCH)-1:0]  out_ch,
    output logic                    busy,
    output logic [CNT_W-1:0]        sample_cnt
);

    localparam int CH_W = $clog2(NCH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CH_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic [6:0]         out_data_q, out_data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NCH-1:0]     eligible, grant;
    logic [CH_W-1:0]    grant_idx, lane;
    logic [3:0]         sel_x;
    logic               found, slot_free, accept, out_hs;

    function automatic logic [CH_W-1:0] lane_at(input logic [CH_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NCH) s = s - NCH;
        return CH_W'(s);
    endfunction

    assign eligible  = req_valid & ch_mask;
    assign out_hs    = out_valid_q & out_ready;
    assign slot_free = ~out_valid_q | out_ready;

    // First eligible lane at or after rr_ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        lane      = '0;
        for (int k = 0; k < NCH; k++) begin
            lane = lane_at(rr_ptr_q, k);
            if (!found && eligible[lane]) begin
                found     = 1'b1;
                grant_idx = lane;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (rst_n && state_q == RUN && en && slot_free && found)
            grant[grant_idx] = 1'b1;
    end

    always_comb begin
        sel_x = '0;
        for (int i = 0; i < NCH; i++)
            if (grant_idx == CH_W'(i)) sel_x = req_data[4*i +: 4];
    end

    assign accept = |(grant & req_valid);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        cnt_d       = out_hs ? cnt_q + 1'b1 : cnt_q;

        case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = DRAIN;
            DRAIN:   if (!out_valid_q || out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            // (x + 8) * 4: flipping the sign bit gives x + 8 as unsigned.
            out_valid_d = 1'b1;
            out_data_d  = {1'b0, ~sel_x[3], sel_x[2:0], 2'b00};
            out_ch_d    = grant_idx;
            rr_ptr_d    = (grant_idx == CH_W'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready  = grant;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign sample_cnt = cnt_q;
    assign busy       = rst_n & ((state_q != IDLE) | out_valid_q);

endmodule

// File: tb/tb_iq_sample_sched.sv
// Bench for iq_sample_sched: cycle model predicts grants and pushes expected
// samples into a queue; output handshakes pop and compare. A CNT_W=4 copy checks wrap.
module tb_iq_sample_sched;

    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           out_ready = 1'b0;
    logic [1:0]     ch_mask = '0;
    logic [1:0]     req_valid = '0;
    logic [7:0]     req_data = '0;

    logic [1:0]     req_ready, req_ready4;
    logic           out_valid, out_valid4;
    logic [6:0]     out_data, out_data4;
    logic           out_ch, out_ch4;
    logic           busy, busy4;
    logic [15:0]    sample_cnt;
    logic [3:0]     sample_cnt4;

    always #5 clk = ~clk;

    iq_sample_sched #(.NCH(NCH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .busy(busy), .sample_cnt(sample_cnt)
    );

    iq_sample_sched #(.NCH(NCH), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_ch(out_ch4), .busy(busy4), .sample_cnt(sample_cnt4)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model, evaluated at the falling edge for the coming rising edge.
    int m_st = 0;    // 0 idle, 1 run, 2 drain
    int m_rr = 0;
    int m_ov = 0;
    int m_cnt = 0;
    int n_hs = 0;
    int exp_q[$];

    always @(negedge clk) begin
        int lane, exp_rdy, exp_busy, nxt_st, xi;
        bit hs;
        logic [3:0] nib;
        if (!rst_n) begin
            chk("rst_rdy", req_ready, 0);
            chk("rst_busy", busy, 0);
            chk("rst_busy4", busy4, 0);
            m_st = 0; m_rr = 0; m_ov = 0; m_cnt = 0;
            exp_q.delete();
        end else begin
            lane = -1;
            if (m_st == 1 && en && (m_ov == 0 || out_ready))
                for (int k = 0; k < NCH; k++) begin
                    int j;
                    j = (m_rr + k) % NCH;
                    if (lane < 0 && req_valid[j] && ch_mask[j]) lane = j;
                end
            exp_rdy  = (lane >= 0) ? (1 << lane) : 0;
            exp_busy = (m_st != 0 || m_ov != 0) ? 1 : 0;
            chk("req_ready", req_ready, exp_rdy);
            chk("req_ready4", req_ready4, exp_rdy);
            chk("busy", busy, exp_busy);
            chk("busy4", busy4, exp_busy);
            chk("out_valid", out_valid, m_ov);
            chk("out_valid4", out_valid4, m_ov);
            chk("sample_cnt", sample_cnt, m_cnt);
            chk("sample_cnt4", sample_cnt4, m_cnt % 16);
            if (m_ov != 0) begin
                if (exp_q.size() == 0) chk("queue_empty", 1, 0);
                else begin
                    chk("out_data", out_data, exp_q[0] % 128);
                    chk("out_ch", out_ch, exp_q[0] / 128);
                    chk("out_data4", out_data4, exp_q[0] % 128);
                    chk("out_ch4", out_ch4, exp_q[0] / 128);
                end
            end
            hs = (m_ov != 0) && out_ready;
            nxt_st = m_st;
            case (m_st)
                0: if (en) nxt_st = 1;
                1: if (!en) nxt_st = 2;
                default: if (m_ov == 0 || out_ready) nxt_st = 0;
            endcase
            m_st = nxt_st;
            if (hs) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                m_cnt = (m_cnt + 1) % 65536;
                n_hs++;
            end
            if (lane >= 0) begin
                nib = req_data[4*lane +: 4];
                xi  = int'($signed(nib));
                exp_q.push_back(lane * 128 + (xi + 8) * 4);
                m_rr = (lane + 1) % NCH;
                m_ov = 1;
            end else if (hs) begin
                m_ov = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_cnt", sample_cnt, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy_after", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hs0;
        rst_n = 1'b0;
        step(2);
        en = 1'b0;
        do_reset();

        // Alternating lanes at full throughput.
        ch_mask = 2'b11; req_valid = 2'b11; req_data = {4'h7, 4'h8}; out_ready = 1'b1;
        en = 1'b1;
        @(negedge clk); chk("alt_cyc0_ov", out_valid, 0);
        @(negedge clk); chk("alt_cyc1_ov", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("alt_ov", out_valid, 1);
            chk("alt_ch", out_ch, i % 2);
            chk("alt_data", out_data, (i % 2) ? 60 : 0);
        end
        @(posedge clk); #1;
        en = 1'b0;
        step(3);
        req_valid = 2'b00;
        step(2);

        // Single lane back-to-back.
        do_reset();
        req_valid = 2'b00; req_data = {4'h3, 4'h0}; out_ready = 1'b1; en = 1'b1;
        step(2);
        req_valid = 2'b10;
        step(10);
        req_valid = 2'b00;
        step(3);
        chk("b2b_cnt", sample_cnt, 10);
        chk("b2b_data", out_data, 44);

        // Output stall holds data and blocks grants.
        do_reset();
        req_data = {4'h0, 4'hF}; req_valid = 2'b01; out_ready = 1'b0; en = 1'b1;
        step(3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", out_data, 28);
            chk("stall_rdy", req_ready, 0);
            step(1);
        end
        out_ready = 1'b1; req_valid = 2'b00;
        step(1);
        chk("stall_release_ov", out_valid, 0);
        chk("stall_release_cnt", sample_cnt, 1);

        // Masked lane never granted.
        do_reset();
        ch_mask = 2'b01; en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            req_valid = 2'b11;
            req_data  = 8'($urandom);
            out_ready = ($urandom % 3) != 0;
            #2 chk("mask_rdy1", req_ready[1], 0);
            step(1);
        end
        en = 1'b0; out_ready = 1'b1;
        step(3);

        // Drain with a sample in flight.
        do_reset();
        ch_mask = 2'b11; req_valid = 2'b01; req_data = 8'h05; out_ready = 1'b0; en = 1'b1;
        step(3);
        en = 1'b0; req_valid = 2'b00;
        step(1);
        step(2);
        en = 1'b1;
        chk("drain_busy", busy, 1);
        step(1);
        chk("drain_hold_busy", busy, 1);
        out_ready = 1'b1; en = 1'b0;
        step(1);
        chk("drain_done_busy", busy, 0);
        chk("drain_done_ov", out_valid, 0);

        // Reset mid-stream, then lane0 first.
        do_reset();
        ch_mask = 2'b11; req_valid = 2'b11; out_ready = 1'b1; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_data = 8'($urandom);
            step(1);
        end
        chk("mid_ov_before", out_valid, 1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        chk("mid_ov_after", out_valid, 0);
        chk("mid_cnt_after", sample_cnt, 0);
        step(1);
        #1 chk("mid_lane0_first", req_ready, 1);
        step(2);
        en = 1'b0; req_valid = 2'b00;
        step(3);

        // 17 outputs on the 4-bit counter wrap to 1.
        do_reset();
        req_valid = 2'b00; out_ready = 1'b1; en = 1'b1; req_data = 8'h2C;
        step(2);
        hs0 = n_hs;
        req_valid = 2'b01;
        step(17);
        req_valid = 2'b00;
        step(2);
        chk("wrap_hs", n_hs - hs0, 17);
        chk("wrap_cnt4", sample_cnt4, 1);
        chk("wrap_cnt16", sample_cnt, 17);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom % 60) != 0;
            en        = ($urandom % 8) != 0;
            ch_mask   = 2'($urandom);
            req_valid = 2'($urandom);
            req_data  = 8'($urandom);
            out_ready = ($urandom % 4) != 0;
            step(1);
        end
        rst_n = 1'b1; en = 1'b0; out_ready = 1'b1; req_valid = 2'b00;
        step(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/iq_sample_sched.md
IQ_SAMPLE_SCHED -- requirements
Module: iq_sample_sched

Interface
REQ-001 Parameter NCH, default 2: number of sample requesters (lanes), range 2..8.
REQ-002 Parameter CNT_W, default 16: width of the delivered-sample counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  scheduler enable (level).
REQ-006 ch_mask  input  NCH  per-lane enable; bit i=0 means lane i is never granted.
REQ-007 req_valid  input  NCH  per-lane sample valid.
REQ-008 req_data  input  4*NCH  per-lane signed 4-bit two's-complement sample; lane i in bits [4i+3:4i].
REQ-009 req_ready  output  NCH  per-lane grant/accept strobe.
REQ-010 out_valid  output  1  converted sample available.
REQ-011 out_ready  input  1  downstream accept.
REQ-012 out_data  output  7  unsigned offset-converted sample.
REQ-013 out_ch  output  clog2(NCH)  lane index of out_data.
REQ-014 busy  output  1  high when state != IDLE or out_valid=1.
REQ-015 sample_cnt  output  CNT_W  count of output handshakes.

Function
REQ-016 The block SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-017 IDLE: all req_ready=0; en=1 -> RUN on next edge.
REQ-018 RUN: en=0 -> DRAIN on next edge; no grant in a cycle where en=0.
REQ-019 DRAIN: no grants; once out_valid=0, or out_valid&out_ready in the current cycle -> IDLE; en re-asserted in DRAIN has no effect until IDLE is reached.
REQ-020 Eligible lane: req_valid[i]=1 and ch_mask[i]=1.
REQ-021 In RUN, at most one req_ready bit SHALL be high per cycle, and only when the output register is empty or out_ready=1 in that cycle (slot free).
REQ-022 Arbitration: round-robin; search starts at pointer rr_ptr, wraps from NCH-1 to 0; grant the first eligible lane.
REQ-023 Accept = req_valid[i] & req_ready[i]; on accept rr_ptr <= (i+1) mod NCH; no accept -> rr_ptr unchanged.
REQ-024 req_ready SHALL be combinational from eligibility, state and slot-free; it SHALL NOT depend on req_data.
REQ-025 Conversion: out_data = (x + 8) * 4 with x the accepted signed sample; range 0 (x=-8) .. 60 (x=+7); bits [6] always 0, [1:0] always 0.
REQ-026 Latency: sample accepted at edge N SHALL appear with out_valid=1, out_data, out_ch at output after edge N (visible cycle N+1).
REQ-027 While out_valid=1 and out_ready=0, out_data/out_ch SHALL hold stable and no grant SHALL occur.
REQ-028 out_valid&out_ready with simultaneous accept: register reloads, out_valid stays 1 (throughput 1 sample/cycle).
REQ-029 out_valid&out_ready with no accept: out_valid <= 0.
REQ-030 sample_cnt SHALL increment by 1 per output handshake, wrapping 2^CNT_W-1 -> 0; it SHALL NOT clear on en toggles.
REQ-031 ch_mask changes take effect in the same cycle; a sample already in the output register is delivered regardless.
REQ-032 A lane lowering req_valid without handshake is legal; the arbiter re-evaluates each cycle.

Reset
REQ-033 rst_n=0 at an edge SHALL force: state=IDLE, rr_ptr=0, out_valid=0, out_data=0, out_ch=0, sample_cnt=0; req_ready=0 and busy=0 while rst_n=0 and on the following cycle.
REQ-034 Reset mid-operation SHALL discard any pending output sample without a handshake.

Verification
REQ-035 NCH=2, en=1, both lanes valid continuously, lane0=-8, lane1=+7, out_ready=1 -> outputs alternate (ch0,0),(ch1,60),(ch0,0)..., one per cycle, first out_valid 2 cycles after en rises.
REQ-036 Single lane1 valid, x=+3, out_ready=1 for 10 cycles -> 10 outputs (ch1,44) back-to-back, sample_cnt=10.
REQ-037 out_ready=0 for 5 cycles with out_valid=1, data=-1 -> out_data=28 held, req_ready=0 throughout, then one handshake on out_ready=1.
REQ-038 ch_mask=2'b01, both lanes valid -> only lane0 ever granted, req_ready[1]=0 always.
REQ-039 en falls with sample in flight, out_ready=0 -> DRAIN, busy=1; out_ready=1 -> handshake, IDLE next edge, busy=0.
REQ-040 rst_n low mid-stream with out_valid=1 -> next cycle out_valid=0, sample_cnt=0, rr_ptr=0 (lane0 granted first after restart); CNT_W=4 run of 17 outputs -> sample_cnt=1.
